// File: rtl/noc_input_queue.sv
// Per-port first-word-fall-through input FIFO feeding the round-robin output arbiter.
// The head packet is presented in arbiter format: bit 0 = valid, bits 1..PL-1 = payload.
module noc_input_queue #(
  parameter int PL    = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:PL-1]    in_packet,
  output logic             in_ready,
  output logic [0:PL-1]    out_packet,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             pop_err
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a packet transfers on a rising edge when in_packet[0] (valid) and
  // in_ready are both high; the head is consumed when pop is high and the queue is
  // not empty. in_ready depends only on registered state, never on in_packet or pop.

  logic [0:PL-1]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign do_push  = in_packet[0] && in_ready;
  assign do_pop   = pop && !empty;

  // Empty queue must present an invalid (all-zero) packet to the arbiter.
  assign out_packet = empty ? '0 : mem[rd_ptr];

  // Storage is intentionally not reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_packet;
  end

  // DEPTH is a power of two, so pointer overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
      if (pop && empty) pop_err <= 1'b1;
    end
  end

endmodule
